// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider: state encoding and width defaults.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // partial_rem < divisor, so the trial's top bit is a reliable borrow flag.
  always_comb begin
    shifted = {partial_rem, next_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider producing {remainder, quotient} for HILO.
// Optional DIV_ZERO_FLAG_EN adds a registered dz_flag output marking divide-by-zero results.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               dz_flag
`endif
);

  localparam int unsigned CntW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state;
  logic [CntW-1:0]  counter;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q;
  logic             sign_r;

  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quo_raw, quo_fix, rem_fix;

  always_comb begin
    neg1    = signed_div & opdata1[WIDTH-1];
    neg2    = signed_div & opdata2[WIDTH-1];
    mag1    = neg1 ? -opdata1 : opdata1;
    mag2    = neg2 ? -opdata2 : opdata2;
    // The dividend register fills with quotient bits as its MSBs shift out.
    quo_raw = {dvd_q[WIDTH-2:0], step_bit};
    quo_fix = sign_q ? -quo_raw : quo_raw;
    rem_fix = sign_r ? -step_rem : step_rem;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_rem(rem_q),
    .divisor    (dvs_q),
    .next_bit   (dvd_q[WIDTH-1]),
    .new_rem    (step_rem),
    .q_bit      (step_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ready   <= 1'b0;
      result  <= '0;
      counter <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_flag <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            dvd_q   <= mag1;
            dvs_q   <= mag2;
            rem_q   <= '0;
            sign_q  <= neg1 ^ neg2;
            sign_r  <= neg1;
            counter <= '0;
            state   <= (opdata2 == '0) ? ST_BYZERO : ST_DIVIDE;
          end
        end
        ST_BYZERO: begin
          if (annul) begin
            state <= ST_IDLE;
            ready <= 1'b0;
          end else begin
            result <= '0;
            ready  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            dz_flag <= 1'b1;
`endif
            state  <= ST_DONE;
          end
        end
        ST_DIVIDE: begin
          if (annul) begin
            state <= ST_IDLE;
            ready <= 1'b0;
          end else begin
            rem_q   <= step_rem;
            dvd_q   <= quo_raw;
            counter <= counter + 1'b1;
            if (counter == LastCnt) begin
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
              dz_flag <= 1'b0;
`endif
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (annul || !start) begin
            state <= ST_IDLE;
            ready <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_flag <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signs, overflow, divide-by-zero, annul, reset.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
`ifdef DIV_ZERO_FLAG_EN
  logic        dz_flag;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .annul     (annul),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .ready     (ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .dz_flag   (dz_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one division; ready must rise exactly at E32. With hold, start stays high one
  // extra cycle to confirm DONE holds; otherwise start drops after E0 and ready pulses once.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input logic hold, input string tag);
    logic early;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    annul      = 1'b0;
    start      = 1'b1;
    cycle();  // E0
    opdata1    = 32'hDEAD_BEEF;
    opdata2    = 32'h0000_0001;
    signed_div = ~sgn;
    if (!hold) start = 1'b0;
    early = 1'b0;
    for (int i = 1; i < 32; i++) begin
      cycle();
      if (ready) early = 1'b1;
    end
    chk({tag, " no early ready"}, 64'(early), 64'd0);
    cycle();  // E32
    chk({tag, " ready at E32"}, 64'(ready), 64'd1);
    chk({tag, " result"}, result, exp);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, " dz_flag"}, 64'(dz_flag), 64'd0);
`endif
    if (hold) begin
      cycle();
      chk({tag, " ready held"}, 64'(ready), 64'd1);
      start = 1'b0;
    end
    cycle();
    chk({tag, " ready dropped"}, 64'(ready), 64'd0);
    chk({tag, " result kept"}, result, exp);
  endtask

  initial begin
    logic quiet;
    reset      = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    cycle();
    cycle();
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset result", result, 64'd0);
    reset = 1'b1;
    cycle();

    do_div(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b1, "u100/7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1, "s-7/2");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0, "uFFFFFFF9/2");

    // Divide by zero: ready one edge after acceptance, result cleared.
    opdata1    = 32'h0000_1234;
    opdata2    = 32'h0;
    signed_div = 1'b0;
    start      = 1'b1;
    cycle();  // E0
    chk("dz not ready at E0", 64'(ready), 64'd0);
    cycle();  // E1
    chk("dz ready at E1", 64'(ready), 64'd1);
    chk("dz result", result, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("dz flag set", 64'(dz_flag), 64'd1);
`endif
    start = 1'b0;
    cycle();
    chk("dz ready dropped", 64'(ready), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("dz flag cleared", 64'(dz_flag), 64'd0);
`endif

    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1'b1, "s-ovf");

    // Annul at E10 of 1000/3, then hold annul with start high: nothing may be accepted.
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    cycle();  // E0
    for (int i = 1; i < 10; i++) cycle();
    annul = 1'b1;
    cycle();  // E10
    chk("annul ready", 64'(ready), 64'd0);
    chk("annul result unchanged", result, {32'h0, 32'h8000_0000});
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ready) quiet = 1'b0;
    end
    chk("annul blocks start", 64'(quiet), 64'd1);
    chk("annul result still unchanged", result, {32'h0, 32'h8000_0000});
    do_div(32'd9, 32'd4, 1'b0, {32'h1, 32'h2}, 1'b0, "u9/4 after annul");

    // Reset at E15 of an operation.
    opdata1    = 32'h0000_1000;
    opdata2    = 32'd3;
    signed_div = 1'b0;
    start      = 1'b1;
    cycle();  // E0
    for (int i = 1; i < 15; i++) cycle();
    reset = 1'b0;
    cycle();  // E15
    chk("midop reset ready", 64'(ready), 64'd0);
    chk("midop reset result", result, 64'd0);
    reset = 1'b1;
    start = 1'b0;
    cycle();
    do_div(32'd50, 32'd5, 1'b0, {32'h0, 32'd10}, 1'b1, "u50/5 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for the EX stage of the 5-stage pipeline.
- Serves DIV and DIVU. EX holds the request and stalls the pipeline until `ready`.
- The 64-bit result {remainder, quotient} is written to HILO through the existing hilo_wr path: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits, result is 2*WIDTH bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request; held high by EX until ready is seen
- annul  input  1  abort the current operation (branch flush/exception)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1  input  WIDTH  dividend
- opdata2  input  WIDTH  divisor
- result  output  2*WIDTH  {remainder, quotient}, registered
- ready  output  1  result valid, registered

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, ready=0, result=0, counter=0. Reset wins over every other input, including mid-operation.
- States are IDLE, BYZERO, DIVIDE, DONE. Define E0 as the clk edge at which start==1 and annul==0 are sampled in IDLE.
- IDLE:
  - At E0, latch signed_div and the operand magnitudes. In signed mode, a negative operand is two's-complement negated.
  - Record sign_q = sign1 XOR sign2 and sign_r = sign1. Both are zero in unsigned mode.
  - If opdata2==0, go to BYZERO; otherwise go to DIVIDE with counter=0.
- DIVIDE (one iteration per cycle):
  - Shift the {partial_rem, dividend} pair left by 1.
  - trial = partial_rem − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative, partial_rem = trial and quotient bit = 1; otherwise keep partial_rem and quotient bit = 0.
  - Counter increments each cycle. The iteration with counter==WIDTH−1 occurs at edge E32.
  - At E32, apply sign correction: negate the quotient if sign_q, negate the remainder if sign_r. Register result, set ready=1, go to DONE.
- BYZERO: at E1, result=0, ready=1, go to DONE.
- DONE:
  - If start==1, hold result and ready.
  - If start==0, go to IDLE at the next edge, with ready=0. result keeps its last value.
- annul==1 at any edge in BYZERO, DIVIDE or DONE: go to IDLE, ready=0. The partial result is discarded and result is unchanged. annul in IDLE blocks acceptance of start.
- start deasserted while in DIVIDE, with no annul: the operation continues to DONE, and ready pulses for one cycle.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000 (wraps), remainder = 0. No trap.
- Operand inputs are ignored after E0; changes mid-operation have no effect.
- Latency: 32 cycles, 1 for divide-by-zero. No back-to-back acceptance; the block passes through IDLE for at least one cycle between operations.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined: adds output port dz_flag (1 bit). It is registered and set to 1 together with ready when the operation went through BYZERO, and 0 otherwise. It clears on reset and on the transition to IDLE.
- Not defined: the port is absent, and divide-by-zero is indistinguishable from a 0/x result. The BYZERO path is unchanged.

Decomposition:
- Shared package:
  - state encoding (2-bit constants ST_IDLE, ST_BYZERO, ST_DIVIDE, ST_DONE)
  - WIDTH default
  - counter width constant (clog2 of WIDTH)
- One natural sub-module: div_step. It is purely combinational: inputs partial_rem, divisor, next dividend bit; outputs new partial_rem and quotient bit. It is instantiated once, and div_unit sequences it.

Test Plan:
- Unsigned 100/7, start held: ready rises exactly at E32; result = {0x00000002, 0x0000000E}; ready drops one cycle after start falls.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also unsigned 0xFFFFFFF9/2: quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 0x1234/0: ready at E1, result 0. With DIV_ZERO_FLAG_EN, dz_flag=1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, ready at E32, no other side effect.
- annul at E10 of a 1000/3 run: IDLE next cycle, ready never asserts, result unchanged. A new start 9/4 then yields {1, 2} at its own E32.
- reset low at E15 of an operation: ready=0 and result=0 after that edge. Start 50/5 after reset deasserts: {0, 10}.
